// File: rtl/pc_pkg.sv
// pc_pkg: definitions shared by the program-counter unit and its return-address stack.
//   nxt_sel_e     - identifies which source wins the next-PC select
//   DEF_RESET_PC  - default PC loaded by reset
//   DEF_EXC_VEC   - default exception vector
//   step_f/sh_f   - PC increment and offset shift for the chosen addressing mode
package pc_pkg;

   typedef enum logic [2:0] {
      SEL_SEQ,
      SEL_BR,
      SEL_JMP,
      SEL_JR,
      SEL_RET,
      SEL_EXC
   } nxt_sel_e;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_0080;

   // Byte addressing steps one 4-byte instruction; word addressing steps 1.
   function automatic int step_f(input bit byte_addr);
      return byte_addr ? 4 : 1;
   endfunction

   // Branch and jump offsets are in instructions, so they scale by the step.
   function automatic int sh_f(input bit byte_addr);
      return byte_addr ? 2 : 0;
   endfunction

endpackage

// File: rtl/pc_unit_ras_stack.sv
// ras_stack: circular return-address stack.
//   i_clk, i_reset  - clock and synchronous active-high reset
//   i_push, i_pop   - push i_din / pop the top entry (never both in one cycle)
//   i_din           - address to push
//   o_top           - most recently pushed entry
//   o_empty, o_full - occupancy flags
//   o_ovf_set       - a push is happening while full (the oldest entry is lost)
module ras_stack #(
   parameter int AW        = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [AW-1:0] i_din,
   output logic [AW-1:0] o_top,
   output logic          o_empty,
   output logic          o_full,
   output logic          o_ovf_set
);

   localparam int PW = $clog2(RAS_DEPTH);

   logic [AW-1:0] r_mem [RAS_DEPTH];
   logic [PW-1:0] r_ptr;   // next slot to write
   logic [PW:0]   r_cnt;
   logic [PW-1:0] w_top_idx;

   assign w_top_idx = r_ptr - PW'(1);
   assign o_top     = r_mem[w_top_idx];
   assign o_empty   = (r_cnt == '0);
   assign o_full    = (r_cnt == (PW+1)'(RAS_DEPTH));
   assign o_ovf_set = i_push & o_full;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ptr <= '0;
         r_cnt <= '0;
      end else if (i_push) begin
         r_ptr <= r_ptr + PW'(1);
         // When full, the write pointer sits on the oldest entry, so the push
         // overwrites it and the count saturates.
         if (!o_full) r_cnt <= r_cnt + (PW+1)'(1);
      end else if (i_pop) begin
         r_ptr <= w_top_idx;
         r_cnt <= r_cnt - (PW+1)'(1);
      end
   end

   // Storage needs no reset: entries are only read when the count says valid.
   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_ptr] <= i_din;
   end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter and next-PC selection for the MIPS core.
//   i_clk, i_reset          - clock, synchronous active-high reset
//   i_stall                 - hold PC, EPC and RAS
//   i_exc_req               - redirect to EXC_VEC, capture EPC
//   i_beq, i_bne, i_zero    - conditional branch controls and ALU zero flag
//   i_imm16                 - signed branch offset in instructions
//   i_jump, i_jal, i_jidx   - absolute jump (jal also pushes the link address)
//   i_jr, i_ret, i_jr_target- register jump; ret pops the RAS instead
//   o_pc, o_pc_plus, o_epc  - current PC, PC + step, exception PC
//   o_ras_miss              - ret taken with an empty RAS (this cycle)
//   o_ras_overflow          - sticky: a push happened with the RAS full
module pc_unit
   import pc_pkg::*;
#(
   parameter int          AW        = 32,
   parameter logic [AW-1:0] RESET_PC = AW'(DEF_RESET_PC),
   parameter logic [AW-1:0] EXC_VEC  = AW'(DEF_EXC_VEC),
   parameter int          BYTE_ADDR = 1,
   parameter int          RAS_DEPTH = 4
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_stall,
   input  logic          i_exc_req,
   input  logic          i_beq,
   input  logic          i_bne,
   input  logic          i_zero,
   input  logic [15:0]   i_imm16,
   input  logic          i_jump,
   input  logic          i_jal,
   input  logic [25:0]   i_jidx,
   input  logic          i_jr,
   input  logic          i_ret,
   input  logic [AW-1:0] i_jr_target,
   output logic [AW-1:0] o_pc,
   output logic [AW-1:0] o_pc_plus,
   output logic [AW-1:0] o_epc,
   output logic          o_ras_miss,
   output logic          o_ras_overflow
);

   localparam int STEP = step_f(BYTE_ADDR != 0);
   localparam int SH   = sh_f(BYTE_ADDR != 0);
   // Bits of the jump target supplied by jidx (plus the zero shift bits);
   // everything above comes from pc_plus.
   localparam logic [AW-1:0] JMASK = (AW'(1) << (26 + SH)) - AW'(1);

   logic [AW-1:0] r_pc;
   logic [AW-1:0] r_epc;
   logic          r_ovf;

   logic [AW-1:0] w_pc_plus;
   logic [AW-1:0] w_imm_sext;
   logic [AW-1:0] w_br_tgt;
   logic [AW-1:0] w_jmp_tgt;
   logic [AW-1:0] w_nxt;
   logic [AW-1:0] w_ras_top;
   logic          w_ras_empty;
   logic          w_ras_full;
   logic          w_ras_ovf_set;
   logic          w_taken;
   logic          w_adv;
   logic          w_push;
   logic          w_pop;
   nxt_sel_e      w_sel;

   assign w_pc_plus  = r_pc + AW'(STEP);
   assign w_imm_sext = {{(AW-16){i_imm16[15]}}, i_imm16};
   assign w_br_tgt   = w_pc_plus + (w_imm_sext << SH);
   assign w_jmp_tgt  = (w_pc_plus & ~JMASK) | (AW'(i_jidx) << SH);
   assign w_taken    = (i_beq & i_zero) | (i_bne & ~i_zero);

   // Priority: exc > (stall) > ret > jr > jal/jump > branch > sequential.
   // Stall is applied at the registers so the select itself stays simple.
   always_comb begin
      w_sel = SEL_SEQ;
      if      (i_exc_req)       w_sel = SEL_EXC;
      else if (i_ret)           w_sel = SEL_RET;
      else if (i_jr)            w_sel = SEL_JR;
      else if (i_jal || i_jump) w_sel = SEL_JMP;
      else if (w_taken)         w_sel = SEL_BR;
   end

   always_comb begin
      w_nxt = w_pc_plus;
      case (w_sel)
         SEL_EXC: w_nxt = EXC_VEC;
         SEL_RET: w_nxt = w_ras_empty ? i_jr_target : w_ras_top;
         SEL_JR:  w_nxt = i_jr_target;
         SEL_JMP: w_nxt = w_jmp_tgt;
         SEL_BR:  w_nxt = w_br_tgt;
         default: w_nxt = w_pc_plus;
      endcase
   end

   // A normal (non-exception, non-stalled) advance; only then may the RAS move.
   assign w_adv  = ~i_reset & ~i_exc_req & ~i_stall;
   assign w_push = w_adv & (w_sel == SEL_JMP) & i_jal;
   assign w_pop  = w_adv & (w_sel == SEL_RET) & ~w_ras_empty;

   ras_stack #(
      .AW        (AW),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_push    (w_push),
      .i_pop     (w_pop),
      .i_din     (w_pc_plus),
      .o_top     (w_ras_top),
      .o_empty   (w_ras_empty),
      .o_full    (w_ras_full),
      .o_ovf_set (w_ras_ovf_set)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pc  <= RESET_PC;
         r_epc <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (i_exc_req) begin
            r_pc  <= EXC_VEC;
            r_epc <= r_pc;
         end else if (!i_stall) begin
            r_pc <= w_nxt;
         end
         if (w_ras_ovf_set) r_ovf <= 1'b1;
      end
   end

   assign o_pc           = r_pc;
   assign o_pc_plus      = w_pc_plus;
   assign o_epc          = r_epc;
   assign o_ras_miss     = w_adv & (w_sel == SEL_RET) & w_ras_empty;
   assign o_ras_overflow = r_ovf;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of pc_unit in byte mode (dut) and word mode (dut0).
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        reset, stall, exc_req, beq, bne, zero, jump, jal, jr, ret;
   logic [15:0] imm16;
   logic [25:0] jidx;
   logic [31:0] jr_target;

   logic [31:0] pc, pc_plus, epc;
   logic        ras_miss, ras_ovf;
   logic [31:0] pc0, pc_plus0, epc0;
   logic        ras_miss0, ras_ovf0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_unit #(.AW(32), .BYTE_ADDR(1), .RAS_DEPTH(4)) dut (
      .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_exc_req(exc_req),
      .i_beq(beq), .i_bne(bne), .i_zero(zero), .i_imm16(imm16),
      .i_jump(jump), .i_jal(jal), .i_jidx(jidx), .i_jr(jr), .i_ret(ret),
      .i_jr_target(jr_target), .o_pc(pc), .o_pc_plus(pc_plus), .o_epc(epc),
      .o_ras_miss(ras_miss), .o_ras_overflow(ras_ovf)
   );

   pc_unit #(.AW(32), .BYTE_ADDR(0), .RAS_DEPTH(4)) dut0 (
      .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_exc_req(exc_req),
      .i_beq(beq), .i_bne(bne), .i_zero(zero), .i_imm16(imm16),
      .i_jump(jump), .i_jal(jal), .i_jidx(jidx), .i_jr(jr), .i_ret(ret),
      .i_jr_target(jr_target), .o_pc(pc0), .o_pc_plus(pc_plus0), .o_epc(epc0),
      .o_ras_miss(ras_miss0), .o_ras_overflow(ras_ovf0)
   );

   task automatic clr();
      reset = 0; stall = 0; exc_req = 0; beq = 0; bne = 0; zero = 0;
      jump = 0; jal = 0; jr = 0; ret = 0; imm16 = '0; jidx = '0; jr_target = '0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic goto(input logic [31:0] a);
      clr(); jr = 1; jr_target = a; tick(); jr = 0;
   endtask

   task automatic do_reset();
      clr(); reset = 1; tick(); tick(); reset = 0;
   endtask

   task automatic test_reset();
      clr(); reset = 1; tick(); tick();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
      checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc got %h exp %h", epc, 32'h0); end
      checks++; if ({ras_miss, ras_ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {ras_miss, ras_ovf}); end
      checks++; if (pc_plus !== 32'h4) begin errors++; $display("FAIL reset_pc_plus got %h exp %h", pc_plus, 32'h4); end
      reset = 0; tick();
      checks++; if (pc !== 32'h4) begin errors++; $display("FAIL seq1 got %h exp %h", pc, 32'h4); end
      tick();
      checks++; if (pc !== 32'h8) begin errors++; $display("FAIL seq2 got %h exp %h", pc, 32'h8); end
      // sequential wrap modulo 2^32
      goto(32'hFFFF_FFFC); tick();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL seq_wrap got %h exp %h", pc, 32'h0); end
   endtask

   task automatic test_branch();
      goto(32'h10); beq = 1; zero = 1; imm16 = 16'hFFFE; tick();
      checks++; if (pc !== 32'h0C) begin errors++; $display("FAIL beq_taken got %h exp %h", pc, 32'h0C); end
      goto(32'h10); beq = 1; zero = 0; imm16 = 16'hFFFE; tick();
      checks++; if (pc !== 32'h14) begin errors++; $display("FAIL beq_not got %h exp %h", pc, 32'h14); end
      goto(32'h10); bne = 1; zero = 0; imm16 = 16'hFFFE; tick();
      checks++; if (pc !== 32'h0C) begin errors++; $display("FAIL bne_taken got %h exp %h", pc, 32'h0C); end
      goto(32'h10); bne = 1; zero = 1; imm16 = 16'hFFFE; tick();
      checks++; if (pc !== 32'h14) begin errors++; $display("FAIL bne_not got %h exp %h", pc, 32'h14); end
      // both conditions requested: taken if either holds
      goto(32'h10); beq = 1; bne = 1; zero = 1; imm16 = 16'h0004; tick();
      checks++; if (pc !== 32'h24) begin errors++; $display("FAIL beq_bne got %h exp %h", pc, 32'h24); end
   endtask

   task automatic test_jal_ret();
      do_reset();
      goto(32'h1000_0040); jal = 1; jidx = 26'h100; tick();
      checks++; if (pc !== 32'h1000_0400) begin errors++; $display("FAIL jal_pc got %h exp %h", pc, 32'h1000_0400); end
      checks++; if (dut.w_ras_top !== 32'h1000_0044) begin errors++; $display("FAIL jal_top got %h exp %h", dut.w_ras_top, 32'h1000_0044); end
      // jr outranks jal: the losing jal must not push
      clr(); jr = 1; jal = 1; jr_target = 32'h500; jidx = 26'h7; tick();
      checks++; if (pc !== 32'h500) begin errors++; $display("FAIL jr_over_jal got %h exp %h", pc, 32'h500); end
      clr(); ret = 1; jr_target = 32'h999; tick();
      checks++; if (pc !== 32'h1000_0044) begin errors++; $display("FAIL ret_pc got %h exp %h", pc, 32'h1000_0044); end
      checks++; if (dut.w_ras_empty !== 1'b1) begin errors++; $display("FAIL ret_empty got %b exp 1", dut.w_ras_empty); end
   endtask

   task automatic test_overflow();
      logic [31:0] exp_ret [4];
      exp_ret[0] = 32'h104; exp_ret[1] = 32'hC4; exp_ret[2] = 32'h84; exp_ret[3] = 32'h44;
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         clr(); jal = 1; jidx = 26'(k * 16); tick();
         checks++; if (pc !== 32'(k * 64)) begin errors++; $display("FAIL jal_push%0d got %h exp %h", k, pc, 32'(k * 64)); end
         if (k == 4) begin
            checks++; if (ras_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", ras_ovf); end
         end
      end
      checks++; if (ras_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ras_ovf); end
      for (int k = 0; k < 4; k++) begin
         clr(); ret = 1; jr_target = 32'h300; #1;
         checks++; if (ras_miss !== 1'b0) begin errors++; $display("FAIL ret_miss%0d got %b exp 0", k, ras_miss); end
         tick();
         checks++; if (pc !== exp_ret[k]) begin errors++; $display("FAIL ret_lifo%0d got %h exp %h", k, pc, exp_ret[k]); end
      end
      clr(); ret = 1; jr_target = 32'h300; #1;
      checks++; if (ras_miss !== 1'b1) begin errors++; $display("FAIL ret_miss_pulse got %b exp 1", ras_miss); end
      tick();
      checks++; if (pc !== 32'h300) begin errors++; $display("FAIL ret_empty_pc got %h exp %h", pc, 32'h300); end
      ret = 0; #1;
      checks++; if (ras_miss !== 1'b0) begin errors++; $display("FAIL ret_miss_clear got %b exp 0", ras_miss); end
      checks++; if (ras_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ras_ovf); end
   endtask

   task automatic test_stall_exc();
      goto(32'h20);
      stall = 1; jal = 1; jidx = 26'h3;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (pc !== 32'h20) begin errors++; $display("FAIL stall_pc%0d got %h exp %h", k, pc, 32'h20); end
      end
      checks++; if (dut.w_ras_empty !== 1'b1) begin errors++; $display("FAIL stall_ras got %b exp 1", dut.w_ras_empty); end
      exc_req = 1; tick();
      checks++; if (pc !== 32'h80) begin errors++; $display("FAIL exc_pc got %h exp %h", pc, 32'h80); end
      checks++; if (epc !== 32'h20) begin errors++; $display("FAIL exc_epc got %h exp %h", epc, 32'h20); end
      checks++; if (dut.w_ras_empty !== 1'b1) begin errors++; $display("FAIL exc_ras got %b exp 1", dut.w_ras_empty); end
      clr(); tick();
      checks++; if (pc !== 32'h84) begin errors++; $display("FAIL post_exc got %h exp %h", pc, 32'h84); end
   endtask

   task automatic test_word_mode();
      do_reset();
      goto(32'h5); beq = 1; zero = 1; imm16 = 16'h0003; tick();
      checks++; if (pc0 !== 32'h9) begin errors++; $display("FAIL word_br got %h exp %h", pc0, 32'h9); end
      goto(32'hFC00_0005); beq = 1; zero = 1; imm16 = 16'h0003; tick();
      checks++; if (pc0 !== 32'hFC00_0009) begin errors++; $display("FAIL word_br_hi got %h exp %h", pc0, 32'hFC00_0009); end
      clr(); jump = 1; jidx = 26'h2A; tick();
      checks++; if (pc0 !== 32'hFC00_002A) begin errors++; $display("FAIL word_jump got %h exp %h", pc0, 32'hFC00_002A); end
      clr(); #1;
      checks++; if (pc_plus0 !== 32'hFC00_002B) begin errors++; $display("FAIL word_pc_plus got %h exp %h", pc_plus0, 32'hFC00_002B); end
   endtask

   initial begin
      clr();
      test_reset();
      test_branch();
      test_jal_ret();
      test_overflow();
      test_stall_exc();
      test_word_mode();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
